sobel_edge_threshold: RTL

//  Downstream stage of sobelFilter. Streams gradient-magnitude words from the SRAM2 read port
//  and compares each 8-bit pixel against a threshold.

---
 rtl/sobel_edge_threshold.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sobel_edge_threshold.sv
// sobel_edge_threshold
//   Downstream stage of the sobel filter. Streams 64-bit gradient-magnitude
//   words (8 pixels, byte 0 = leftmost) from the magnitude SRAM and
//   thresholds each pixel. A pixel is an edge when it is strictly greater
//   than the latched threshold. The binary edge map (0xFF edge, 0x00
//   background) is written to an output SRAM. Edge pixels are counted with
//   a saturating counter for the particle detector.
//
//   Optional feature macro: BORDER_MASK_EN
//     When defined, byte 0 of a word at column 0 and byte 7 of a word at the
//     last column of a row are forced to background and not counted. This
//     suppresses the invalid sobel response on the image border.
//
// Ports
//   clk         in   1   system clock, all state on posedge
//   reset       in   1   asynchronous, active-low reset
//   startEn     in   1   one-cycle start pulse, ignored while busy
//   thresh      in   8   magnitude threshold, sampled on an accepted start
//   read_addr   out  20  magnitude SRAM read address
//   q_mag       in   64  magnitude SRAM read data (valid 2 edges after address)
//   we_out      out  1   edge-map SRAM write enable
//   write_addr  out  20  edge-map SRAM write address
//   data_out    out  64  edge-map word
//   edgeCount   out  20  edge pixels found this frame, saturating
//   busy        out  1   high from accepted start until done
//   done        out  1   one-cycle pulse after the last write
//   state_dbg   out  2   current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
//
// EDGE_MAX is the saturation value of edgeCount (20'hFFFFF in a real frame).

module sobel_edge_threshold #(
    parameter logic [19:0] START_ADDR    = 20'd768,
    parameter logic [19:0] NUM_WORDS     = 20'd64768,
    parameter logic [19:0] OUT_BASE      = 20'd0,
    parameter int          WORDS_PER_ROW = 256,
    parameter logic [19:0] EDGE_MAX      = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startEn,
    input  logic [7:0]  thresh,
    output logic [19:0] read_addr,
    input  logic [63:0] q_mag,
    output logic        we_out,
    output logic [19:0] write_addr,
    output logic [63:0] data_out,
    output logic [19:0] edgeCount,
    output logic        busy,
    output logic        done,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [19:0] LAST_ADDR = START_ADDR + NUM_WORDS - 20'd1;
    localparam logic [7:0]  LAST_COL  = 8'(WORDS_PER_ROW - 1);

`ifdef BORDER_MASK_EN
    localparam bit MASK_BORDERS = 1'b1;
`else
    localparam bit MASK_BORDERS = 1'b0;
`endif

    state_t      state;
    logic [7:0]  thresh_r;

    // Read pipeline. s1 marks the address issued at the last edge, s2 the
    // cycle in which the SRAM is reading it, s3 holds the captured data.
    logic        s1_valid;
    logic        s2_valid;
    logic [19:0] s2_addr;
    logic        s3_valid;
    logic [19:0] s3_addr;
    logic [63:0] s3_q;

    logic [7:0]  edge_flags;
    logic [63:0] edge_word;
    logic [3:0]  edge_pop;
    logic [20:0] count_sum;
    logic [19:0] count_next;
    logic        col_first;
    logic        col_last;

    assign state_dbg = state;

    // Column position within a row is the low byte of the word address.
    assign col_first = (s3_addr[7:0] == 8'd0);
    assign col_last  = (s3_addr[7:0] == LAST_COL);

    always_comb begin
        edge_flags = '0;
        edge_word  = '0;
        edge_pop   = '0;
        for (int i = 0; i < 8; i++) begin
            edge_flags[i] = (s3_q[8*i +: 8] > thresh_r);
        end
        if (MASK_BORDERS && col_first) edge_flags[0] = 1'b0;
        if (MASK_BORDERS && col_last)  edge_flags[7] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            edge_word[8*i +: 8] = {8{edge_flags[i]}};
            edge_pop            = edge_pop + {3'b000, edge_flags[i]};
        end
        // Counter never exceeds EDGE_MAX, so one compare on the widened sum
        // is enough to saturate without wrapping.
        count_sum  = {1'b0, edgeCount} + {17'd0, edge_pop};
        count_next = (count_sum > {1'b0, EDGE_MAX}) ? EDGE_MAX : count_sum[19:0];
    end

    // Start handshake: startEn is a one-cycle request that is accepted only
    // in IDLE (busy=0); there is no ready signal, a request made while busy
    // is dropped and never queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            thresh_r   <= '0;
            read_addr  <= '0;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s2_addr    <= '0;
            s3_valid   <= 1'b0;
            s3_addr    <= '0;
            s3_q       <= '0;
            we_out     <= 1'b0;
            write_addr <= '0;
            data_out   <= '0;
            edgeCount  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            s2_valid <= s1_valid;
            s2_addr  <= read_addr;
            s3_valid <= s2_valid;
            s3_addr  <= s2_addr;
            if (s2_valid) begin
                s3_q <= q_mag;
            end

            // Output stage: address and data hold their last value when idle.
            we_out <= s3_valid;
            if (s3_valid) begin
                write_addr <= s3_addr - START_ADDR + OUT_BASE;
                data_out   <= edge_word;
                edgeCount  <= count_next;
            end

            case (state)
                IDLE: begin
                    s1_valid <= 1'b0;
                    if (startEn) begin
                        thresh_r  <= thresh;
                        edgeCount <= '0;
                        read_addr <= START_ADDR;
                        s1_valid  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (read_addr == LAST_ADDR) begin
                        s1_valid <= 1'b0;
                        state    <= DRAIN;
                    end else begin
                        read_addr <= read_addr + 20'd1;
                        s1_valid  <= 1'b1;
                    end
                end
                DRAIN: begin
                    s1_valid <= 1'b0;
                    // Leave only after the final write has been presented.
                    if (!s1_valid && !s2_valid && !s3_valid && !we_out) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
